// File: rtl/priv_trap_sequencer.sv
// -----------------------------------------------------------------------------
// priv_trap_sequencer
//
// Machine-mode trap entry / MRET sequencer. One event at a time is accepted in
// IDLE (exception > MRET > enabled interrupt, with MEI > MSI > MTI). The
// pipeline is then drained and one atomic CSR update is issued. Fetch is then
// redirected to the trap vector or the MRET target. This block owns the current
// privilege level.
//
// Ports
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   ex_valid/_cause/   exception on the oldest instruction, its cause,
//   ex_pc/ex_tval      PC and trap value
//   int_pc             PC of next unretired instruction (mepc for interrupts)
//   mret_req           MRET at commit
//   mip_reg, mie_reg   pending / enabled interrupt CSRs
//   mstatus_mie/mpie/  current mstatus fields
//   mstatus_mpp
//   mtvec_reg          trap vector base + mode
//   mepc_reg           current mepc (MRET target)
//   pipe_drained       pipeline empty, no outstanding memory ops
//   redirect_ack       fetch accepted the redirect
//   flush_req          pipeline flush/drain request (DRAIN and COMMIT)
//   csr_wen            one-cycle strobe applying all CSR outputs below
//   trap_not_ret       1: trap entry (mcause/mepc/mtval valid), 0: MRET
//   mcause_o, mepc_o,  new CSR values, valid while csr_wen is high
//   mtval_o, mie_o,
//   mpie_o, mpp_o
//   priv_o             current privilege level (registered)
//   redirect_valid/pc  fetch redirect request and target
//   dbg_state_o        current FSM state (IDLE=0, DRAIN=1, COMMIT=2, REDIRECT=3)
//
// Redirect handshake: redirect_valid rises in REDIRECT and stays high with
// redirect_pc stable until a cycle in which redirect_ack is sampled high; that
// cycle completes the transfer and the FSM returns to IDLE on the same edge.
// -----------------------------------------------------------------------------
module priv_trap_sequencer #(
  parameter logic [1:0] RESET_PRIV = 2'h3,
  parameter bit         HAS_U_MODE = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ex_valid,
  input  logic [30:0] ex_cause,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_tval,
  input  logic [31:0] int_pc,
  input  logic        mret_req,
  input  logic [31:0] mip_reg,
  input  logic [31:0] mie_reg,
  input  logic        mstatus_mie,
  input  logic        mstatus_mpie,
  input  logic [1:0]  mstatus_mpp,
  input  logic [31:0] mtvec_reg,
  input  logic [31:0] mepc_reg,
  input  logic        pipe_drained,
  input  logic        redirect_ack,
  output logic        flush_req,
  output logic        csr_wen,
  output logic        trap_not_ret,
  output logic [31:0] mcause_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mtval_o,
  output logic        mie_o,
  output logic        mpie_o,
  output logic [1:0]  mpp_o,
  output logic [1:0]  priv_o,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_COMMIT   = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  localparam logic [1:0]  U_MODE        = 2'd0;
  localparam logic [1:0]  RESERVED_MODE = 2'd2;
  localparam logic [1:0]  M_MODE        = 2'd3;
  localparam logic [1:0]  TVEC_VECTORED = 2'd1;
  localparam logic [31:0] IRQ_MASK      = 32'h0000_0888; // MEI(11), MTI(7), MSI(3)
  localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic [1:0]  priv_q, priv_d;
  logic        is_irq_q, is_irq_d;
  logic        is_mret_q, is_mret_d;
  logic [30:0] cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        flush_q, flush_d;
  logic        csr_wen_q, csr_wen_d;
  logic        redirect_valid_q, redirect_valid_d;

  // Interrupt selection
  logic [31:0] irq_pend;
  logic        irq_any;
  logic        irq_en;
  logic [30:0] irq_cause;

  // Values produced during COMMIT
  logic [31:0] commit_target;
  logic [1:0]  commit_priv;
  logic [31:0] vec_offset;

  always_comb begin
    irq_pend = mip_reg & mie_reg & IRQ_MASK;
    irq_any  = |irq_pend;
    // Lower privilege can always be interrupted by M-mode interrupts.
    irq_en   = (priv_q != M_MODE) | mstatus_mie;
    if (irq_pend[11])     irq_cause = 31'd11;
    else if (irq_pend[3]) irq_cause = 31'd3;
    else                  irq_cause = 31'd7;
  end

  // Trap/MRET target and privilege, evaluated from live CSR inputs in COMMIT.
  always_comb begin
    vec_offset = '0;
    if ((mtvec_reg[1:0] == TVEC_VECTORED) && is_irq_q) begin
      vec_offset = {1'b0, cause_q} << 2;
    end
    if (is_mret_q) begin
      commit_target = mepc_reg & ALIGN_MASK;
      if (mstatus_mpp == RESERVED_MODE) begin
        commit_priv = HAS_U_MODE ? U_MODE : M_MODE;
      end else begin
        commit_priv = mstatus_mpp;
      end
    end else begin
      commit_target = (mtvec_reg & ALIGN_MASK) + vec_offset;
      commit_priv   = M_MODE;
    end
  end

  // CSR update payload, only driven while the strobe is high.
  always_comb begin
    trap_not_ret = 1'b0;
    mcause_o     = '0;
    mepc_o       = '0;
    mtval_o      = '0;
    mie_o        = 1'b0;
    mpie_o       = 1'b0;
    mpp_o        = '0;
    if (state_q == S_COMMIT) begin
      if (is_mret_q) begin
        mie_o  = mstatus_mpie;
        mpie_o = 1'b1;
        mpp_o  = HAS_U_MODE ? U_MODE : M_MODE;
      end else begin
        trap_not_ret = 1'b1;
        mcause_o     = {is_irq_q, cause_q};
        mepc_o       = pc_q & ALIGN_MASK;
        mtval_o      = is_irq_q ? 32'h0 : tval_q;
        mie_o        = 1'b0;
        mpie_o       = mstatus_mie;
        mpp_o        = priv_q;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    priv_d        = priv_q;
    is_irq_d      = is_irq_q;
    is_mret_d     = is_mret_q;
    cause_d       = cause_q;
    pc_d          = pc_q;
    tval_d        = tval_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      S_IDLE: begin
        // Losing events are not queued; they are seen again on the next IDLE.
        if (ex_valid) begin
          is_irq_d  = 1'b0;
          is_mret_d = 1'b0;
          cause_d   = ex_cause;
          pc_d      = ex_pc;
          tval_d    = ex_tval;
          state_d   = S_DRAIN;
        end else if (mret_req) begin
          is_irq_d  = 1'b0;
          is_mret_d = 1'b1;
          cause_d   = '0;
          pc_d      = '0;
          tval_d    = '0;
          state_d   = S_DRAIN;
        end else if (irq_en && irq_any) begin
          is_irq_d  = 1'b1;
          is_mret_d = 1'b0;
          cause_d   = irq_cause;
          pc_d      = int_pc;
          tval_d    = '0;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pipe_drained) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        priv_d        = commit_priv;
        redirect_pc_d = commit_target;
        state_d       = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (redirect_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    flush_d          = (state_d == S_DRAIN) || (state_d == S_COMMIT);
    csr_wen_d        = (state_d == S_COMMIT);
    redirect_valid_d = (state_d == S_REDIRECT);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q          <= S_IDLE;
      priv_q           <= RESET_PRIV;
      is_irq_q         <= 1'b0;
      is_mret_q        <= 1'b0;
      cause_q          <= '0;
      pc_q             <= '0;
      tval_q           <= '0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      csr_wen_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      priv_q           <= priv_d;
      is_irq_q         <= is_irq_d;
      is_mret_q        <= is_mret_d;
      cause_q          <= cause_d;
      pc_q             <= pc_d;
      tval_q           <= tval_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      csr_wen_q        <= csr_wen_d;
      redirect_valid_q <= redirect_valid_d;
    end
  end

  assign flush_req      = flush_q;
  assign csr_wen        = csr_wen_q;
  assign priv_o         = priv_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_priv_trap_sequencer.sv
module tb_priv_trap_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nrst;

  logic        ex_valid, mret_req, mstatus_mie, mstatus_mpie, pipe_drained, redirect_ack;
  logic [30:0] ex_cause;
  logic [31:0] ex_pc, ex_tval, int_pc, mip_reg, mie_reg, mtvec_reg, mepc_reg;
  logic [1:0]  mstatus_mpp;
  logic        flush_req, csr_wen, trap_not_ret, mie_o, mpie_o, redirect_valid;
  logic [31:0] mcause_o, mepc_o, mtval_o, redirect_pc;
  logic [1:0]  mpp_o, priv_o, dbg_state;

  priv_trap_sequencer #(.RESET_PRIV(2'h3), .HAS_U_MODE(1'b1)) dut (
    .CLK(clk), .nRST(nrst),
    .ex_valid(ex_valid), .ex_cause(ex_cause), .ex_pc(ex_pc), .ex_tval(ex_tval),
    .int_pc(int_pc), .mret_req(mret_req), .mip_reg(mip_reg), .mie_reg(mie_reg),
    .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie), .mstatus_mpp(mstatus_mpp),
    .mtvec_reg(mtvec_reg), .mepc_reg(mepc_reg), .pipe_drained(pipe_drained),
    .redirect_ack(redirect_ack), .flush_req(flush_req), .csr_wen(csr_wen),
    .trap_not_ret(trap_not_ret), .mcause_o(mcause_o), .mepc_o(mepc_o), .mtval_o(mtval_o),
    .mie_o(mie_o), .mpie_o(mpie_o), .mpp_o(mpp_o), .priv_o(priv_o),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dbg_state_o(dbg_state)
  );

  // ---------------- vectors ----------------
  typedef struct {
    bit          follow;    // event already pending from previous entry: drive without waiting
    bit          keep_irq;  // leave mip asserted after the event is accepted
    logic        ex_valid;
    logic [30:0] ex_cause;
    logic [31:0] ex_pc, ex_tval, int_pc;
    logic        mret;
    logic [31:0] mip, mie;
    logic        st_mie, st_mpie;
    logic [1:0]  st_mpp;
    logic [31:0] mtvec, mepc;
    int          drain;
    bit          exp_take, exp_trap;
    logic [31:0] exp_mcause, exp_mepc, exp_mtval;
    logic        exp_mie, exp_mpie;
    logic [1:0]  exp_mpp, exp_priv;
    logic [31:0] exp_pc;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0] priv_m;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  function automatic vec_t vin(input bit follow, input bit keep, input logic exv,
                               input logic [30:0] cause, input logic [31:0] expc,
                               input logic [31:0] tval, input logic [31:0] ipc,
                               input logic mret, input logic [31:0] mip, input logic [31:0] mie,
                               input logic smie, input logic smpie, input logic [1:0] smpp,
                               input logic [31:0] mtvec, input logic [31:0] mepc, input int drain);
    vec_t v;
    v = '{default: '0};
    v.follow = follow; v.keep_irq = keep; v.ex_valid = exv; v.ex_cause = cause;
    v.ex_pc = expc; v.ex_tval = tval; v.int_pc = ipc; v.mret = mret; v.mip = mip;
    v.mie = mie; v.st_mie = smie; v.st_mpie = smpie; v.st_mpp = smpp;
    v.mtvec = mtvec; v.mepc = mepc; v.drain = drain;
    return v;
  endfunction

  function automatic vec_t vexp(input vec_t v, input bit take, input bit trap,
                                input logic [31:0] mc, input logic [31:0] me, input logic [31:0] mt,
                                input logic mi, input logic mp, input logic [1:0] mpp,
                                input logic [1:0] pv, input logic [31:0] pc);
    vec_t r;
    r = v;
    r.exp_take = take; r.exp_trap = trap; r.exp_mcause = mc; r.exp_mepc = me;
    r.exp_mtval = mt; r.exp_mie = mi; r.exp_mpie = mp; r.exp_mpp = mpp;
    r.exp_priv = pv; r.exp_pc = pc;
    return r;
  endfunction

  // Reference model: decides the winning event and its architectural effect.
  function automatic vec_t predict(input vec_t v, input logic [1:0] priv);
    vec_t r;
    logic [31:0] pend;
    int order[3];
    int code;
    r = v;
    order[0] = 11; order[1] = 3; order[2] = 7;
    pend = v.mip & v.mie;
    code = -1;
    for (int i = 0; i < 3; i++) if (code < 0 && pend[order[i]]) code = order[i];
    r.exp_take = 1; r.exp_trap = 1; r.exp_priv = 2'd3;
    r.exp_mie = 1'b0; r.exp_mpie = v.st_mie; r.exp_mpp = priv;
    r.exp_mcause = 0; r.exp_mepc = 0; r.exp_mtval = 0; r.exp_pc = 0;
    if (v.ex_valid) begin
      r.exp_mcause = {1'b0, v.ex_cause};
      r.exp_mepc   = v.ex_pc & ~32'h3;
      r.exp_mtval  = v.ex_tval;
      r.exp_pc     = v.mtvec & ~32'h3;
    end else if (v.mret) begin
      r.exp_trap = 0;
      r.exp_mie  = v.st_mpie;
      r.exp_mpie = 1'b1;
      r.exp_mpp  = 2'd0;
      r.exp_priv = (v.st_mpp == 2'd2) ? 2'd0 : v.st_mpp;
      r.exp_pc   = v.mepc & ~32'h3;
    end else if (code >= 0 && (priv != 2'd3 || v.st_mie)) begin
      r.exp_mcause = 32'h8000_0000 | 32'(code);
      r.exp_mepc   = v.int_pc & ~32'h3;
      r.exp_pc     = (v.mtvec & ~32'h3) + ((v.mtvec % 4 == 1) ? 32'(4 * code) : 32'd0);
    end else begin
      r.exp_take = 0; r.exp_trap = 0; r.exp_priv = priv;
      r.exp_mie = 0; r.exp_mpie = 0; r.exp_mpp = 0;
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    ex_valid = v.ex_valid; ex_cause = v.ex_cause; ex_pc = v.ex_pc; ex_tval = v.ex_tval;
    int_pc = v.int_pc; mret_req = v.mret; mip_reg = v.mip; mie_reg = v.mie;
    mstatus_mie = v.st_mie; mstatus_mpie = v.st_mpie; mstatus_mpp = v.st_mpp;
    mtvec_reg = v.mtvec; mepc_reg = v.mepc; pipe_drained = 1'b0; redirect_ack = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int wen_cnt, wen_cyc, rdy_cyc;
    logic [31:0] pc_seen;
    bit bad;
    wen_cnt = 0; wen_cyc = -1; rdy_cyc = -1; bad = 0;
    if (!v.follow) begin
      @(posedge clk); #1;
    end
    drive(v);
    if (!v.exp_take) begin
      for (int k = 1; k <= 4; k++) begin
        @(posedge clk); #1; pipe_drained = 1'b1;
        @(negedge clk);
        if (flush_req || csr_wen || redirect_valid) bad = 1;
      end
      check({tag, "_no_trap"}, 32'(bad), 32'd0);
      check({tag, "_priv_kept"}, 32'(priv_o), 32'(priv_m));
      ex_valid = 0; mret_req = 0; mip_reg = 0; pipe_drained = 0;
      return;
    end
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        ex_valid = 0; mret_req = 0;
        if (!v.keep_irq) mip_reg = 0;
      end
      pipe_drained = (k >= v.drain);
      @(negedge clk);
      if (k == 1) check({tag, "_flush_drain"}, 32'(flush_req), 32'd1);
      if (csr_wen) begin
        wen_cnt++;
        if (wen_cyc < 0) begin
          wen_cyc = k;
          check({tag, "_flush_commit"}, 32'(flush_req), 32'd1);
          check({tag, "_trap_not_ret"}, 32'(trap_not_ret), 32'(v.exp_trap));
          check({tag, "_mie_o"}, 32'(mie_o), 32'(v.exp_mie));
          check({tag, "_mpie_o"}, 32'(mpie_o), 32'(v.exp_mpie));
          check({tag, "_mpp_o"}, 32'(mpp_o), 32'(v.exp_mpp));
          if (v.exp_trap) begin
            check({tag, "_mcause"}, mcause_o, v.exp_mcause);
            check({tag, "_mepc"}, mepc_o, v.exp_mepc);
            check({tag, "_mtval"}, mtval_o, v.exp_mtval);
          end
        end
      end
      if (redirect_valid) begin
        rdy_cyc = k;
        break;
      end
    end
    check({tag, "_wen_count"}, 32'(wen_cnt), 32'd1);
    check({tag, "_wen_cycle"}, 32'(wen_cyc), 32'(v.drain + 1));
    check({tag, "_redirect_latency"}, 32'(rdy_cyc), 32'(v.drain + 2));
    check({tag, "_redirect_pc"}, redirect_pc, v.exp_pc);
    check({tag, "_flush_redirect"}, 32'(flush_req), 32'd0);
    pc_seen = redirect_pc;
    // One cycle without ack: request must hold.
    @(posedge clk); #1; pipe_drained = 0;
    @(negedge clk);
    check({tag, "_redirect_hold"}, 32'(redirect_valid), 32'd1);
    check({tag, "_redirect_pc_stable"}, redirect_pc, pc_seen);
    @(posedge clk); #1; redirect_ack = 1;
    @(posedge clk); #1; redirect_ack = 0;
    @(negedge clk);
    check({tag, "_redirect_done"}, 32'(redirect_valid), 32'd0);
    check({tag, "_priv"}, 32'(priv_o), 32'(v.exp_priv));
    priv_m = v.exp_priv;
  endtask

  // ---------------- test ----------------
  vec_t tbl[10];
  vec_t rv;
  bit   bad_rst;

  initial begin
    tbl[0] = vexp(vin(0,0, 1,31'd2,32'h100,32'hDEAD,32'h0, 0, 32'h0,32'h0, 1,0,2'd0, 32'h8000_0000,32'h0, 2),
                  1,1, 32'h2,32'h100,32'hDEAD, 0,1,2'd3, 2'd3, 32'h8000_0000);
    tbl[1] = vexp(vin(0,0, 0,31'd0,32'h0,32'h0,32'h204, 0, 32'h80,32'h80, 1,0,2'd0, 32'h8000_0001,32'h0, 1),
                  1,1, 32'h8000_0007,32'h204,32'h0, 0,1,2'd3, 2'd3, 32'h8000_001C);
    tbl[2] = vexp(vin(0,0, 0,31'd0,32'h0,32'h0,32'h300, 0, 32'h880,32'h880, 1,0,2'd0, 32'h8000_0001,32'h0, 2),
                  1,1, 32'h8000_000B,32'h300,32'h0, 0,1,2'd3, 2'd3, 32'h8000_002C);
    tbl[3] = vexp(vin(0,0, 0,31'd0,32'h0,32'h0,32'h300, 0, 32'h880,32'h880, 0,0,2'd0, 32'h8000_0001,32'h0, 1),
                  0,0, 32'h0,32'h0,32'h0, 0,0,2'd0, 2'd3, 32'h0);
    tbl[4] = vexp(vin(0,0, 0,31'd0,32'h0,32'h0,32'h0, 1, 32'h0,32'h0, 0,1,2'd0, 32'h0,32'h3002, 1),
                  1,0, 32'h0,32'h0,32'h0, 1,1,2'd0, 2'd0, 32'h3000);
    tbl[5] = vexp(vin(0,0, 0,31'd0,32'h0,32'h0,32'h400, 0, 32'h8,32'h8, 0,1,2'd0, 32'h1000,32'h0, 3),
                  1,1, 32'h8000_0003,32'h400,32'h0, 0,0,2'd0, 2'd3, 32'h1000);
    tbl[6] = vexp(vin(0,1, 1,31'd5,32'h500,32'h55,32'h504, 0, 32'h800,32'h800, 1,0,2'd0, 32'h2001,32'h0, 1),
                  1,1, 32'h5,32'h500,32'h55, 0,1,2'd3, 2'd3, 32'h2000);
    tbl[7] = vexp(vin(1,0, 0,31'd0,32'h0,32'h0,32'h504, 0, 32'h800,32'h800, 1,0,2'd0, 32'h2001,32'h0, 2),
                  1,1, 32'h8000_000B,32'h504,32'h0, 0,1,2'd3, 2'd3, 32'h202C);
    tbl[8] = vexp(vin(0,0, 0,31'd0,32'h0,32'h0,32'h604, 0, 32'h8,32'h8, 1,0,2'd0, 32'h4003,32'h0, 1),
                  1,1, 32'h8000_0003,32'h604,32'h0, 0,1,2'd3, 2'd3, 32'h4000);
    tbl[9] = vexp(vin(0,0, 0,31'd0,32'h0,32'h0,32'h0, 1, 32'h0,32'h0, 1,0,2'd2, 32'h0,32'h7777, 1),
                  1,0, 32'h0,32'h0,32'h0, 0,1,2'd0, 2'd0, 32'h7774);

    nrst = 1'b0;
    drive(vin(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1));
    priv_m = 2'd3;
    #12;
    check("reset_priv", 32'(priv_o), 32'd3);
    check("reset_ctrl", 32'({flush_req, csr_wen, trap_not_ret, mie_o, mpie_o, mpp_o, redirect_valid, dbg_state}), 32'd0);
    check("reset_mcause", mcause_o, 32'd0);
    check("reset_redirect_pc", redirect_pc, 32'd0);
    @(posedge clk); #1; nrst = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Reset while draining: no CSR write, privilege back to reset value.
    @(posedge clk); #1;
    ex_valid = 1; ex_cause = 31'd1; ex_pc = 32'h800; pipe_drained = 0;
    @(posedge clk); #1; ex_valid = 0;
    @(negedge clk);
    check("rst_mid_flush_before", 32'(flush_req), 32'd1);
    #1 nrst = 1'b0;
    #1;
    check("rst_mid_priv", 32'(priv_o), 32'd3);
    check("rst_mid_ctrl", 32'({flush_req, csr_wen, redirect_valid, dbg_state}), 32'd0);
    @(posedge clk); #1; nrst = 1'b1; pipe_drained = 1;
    bad_rst = 0;
    repeat (6) begin
      @(negedge clk);
      if (csr_wen || redirect_valid || flush_req) bad_rst = 1;
    end
    check("rst_mid_no_wen", 32'(bad_rst), 32'd0);
    pipe_drained = 0;
    priv_m = 2'd3;

    // Randomized events against the reference model.
    for (int i = 0; i < 40; i++) begin
      rv = vin(0, 0, ($urandom_range(0, 2) == 0), 31'($urandom_range(0, 15)), $urandom, $urandom,
               $urandom, ($urandom_range(0, 2) == 0), $urandom, $urandom,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               $urandom, $urandom, $urandom_range(1, 4));
      rv = predict(rv, priv_m);
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
